// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main controller and its datapath.
// master: the controller (drives strobes/selects); slave: datapath + memory.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style main control FSM for the multicycle CPU.
// Drives all datapath selects and strobes; memory states stall on mem_ready.
// Optional feature macro: CTRL_ADDI_EN (decodes ADDI via states AEX/AWB).
module multicycle_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BEQ   = 4'd8,
        S_JMP   = 4'd9,
        S_AEX   = 4'd10,
        S_AWB   = 4'd11
    } state_t;

    state_t state_q;

    // State register and next-state logic; unknown encodings recover to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    if (bus.mem_ready) state_q <= S_ID;
                S_ID: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_q <= S_MADDR;
                        OP_R:         state_q <= S_REX;
                        OP_BEQ:       state_q <= S_BEQ;
                        OP_J:         state_q <= S_JMP;
`ifdef CTRL_ADDI_EN
                        OP_ADDI:      state_q <= S_AEX;
`endif
                        default:      state_q <= S_IF;
                    endcase
                end
                S_MADDR: state_q <= (bus.opcode == OP_LW) ? S_MRD :
                                    (bus.opcode == OP_SW) ? S_MWR : S_IF;
                S_MRD:   if (bus.mem_ready) state_q <= S_MWB;
                S_MWB:   state_q <= S_IF;
                S_MWR:   if (bus.mem_ready) state_q <= S_IF;
                S_REX:   state_q <= S_RWB;
                S_RWB:   state_q <= S_IF;
                S_BEQ:   state_q <= S_IF;
                S_JMP:   state_q <= S_IF;
`ifdef CTRL_ADDI_EN
                S_AEX:   state_q <= S_AWB;
                S_AWB:   state_q <= S_IF;
`endif
                default: state_q <= S_IF;
            endcase
        end
    end

    // Output decode: pure function of state, plus mem_ready in IF and opcode in ID.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 2'd0;
        bus.pc_source     = 2'd0;
        bus.illegal_op    = 1'b0;
        case (state_q)
            S_IF: begin
                // PC+4 computed every fetch cycle; loads gated by memory completion
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_ID: begin
                bus.alu_src_b = 2'd3;
                case (bus.opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: bus.illegal_op = 1'b0;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:                          bus.illegal_op = 1'b0;
`endif
                    default:                          bus.illegal_op = 1'b1;
                endcase
            end
            S_MADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_MRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'd2;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'd1;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'd1;
            end
            S_JMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd2;
            end
`ifdef CTRL_ADDI_EN
            S_AEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_AWB: begin
                bus.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into the
// expected per-cycle state trace (with random memory stalls) and every cycle's
// state and full output vector are compared against the spec's state table.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

`ifdef CTRL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (ADDI_ON && op == OP_ADDI);
    endfunction

    // Order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
    //        mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source illegal_op
    function automatic logic [16:0] got_outs();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
    endfunction

    // Spec state table as expected output vectors.
    function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, il;
        logic [1:0] asb, aop, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, il} = '0;
        asb = 0; aop = 0; ps = 0;
        case (st)
            0:  begin mr = 1; asb = 1; irw = rdy; pw = rdy; end
            1:  begin asb = 3; il = ill; end
            2:  begin asa = 1; asb = 2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 1; pwc = 1; ps = 1; end
            9:  begin pw = 1; ps = 2; end
            10: if (ADDI_ON) begin asa = 1; asb = 2; end
            11: if (ADDI_ON) rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, il};
    endfunction

    // One cycle: drive inputs just after negedge, compare before the next posedge.
    task automatic step(input int st, input bit rdy, input logic [5:0] op);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #1;
        chk("state", 32'(bus.state), 32'(st));
        chk("outs", 32'(got_outs()), 32'(exp_out(st, rdy, (st == 1) && !legal(op))));
    endtask

    // Expand an instruction into its expected state trace, then run it.
    task automatic run_instr(input logic [5:0] op, input int if_st, input int mem_st);
        step_t q[$];
        for (int i = 0; i < if_st; i++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'($urandom)});
        if (legal(op)) begin
            case (op)
                OP_LW: begin
                    q.push_back('{2, 1'($urandom)});
                    for (int i = 0; i < mem_st; i++) q.push_back('{3, 1'b0});
                    q.push_back('{3, 1'b1});
                    q.push_back('{4, 1'($urandom)});
                end
                OP_SW: begin
                    q.push_back('{2, 1'($urandom)});
                    for (int i = 0; i < mem_st; i++) q.push_back('{5, 1'b0});
                    q.push_back('{5, 1'b1});
                end
                OP_R:    begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
                OP_BEQ:  q.push_back('{8, 1'($urandom)});
                OP_J:    q.push_back('{9, 1'($urandom)});
                default: begin q.push_back('{10, 1'($urandom)}); q.push_back('{11, 1'($urandom)}); end
            endcase
        end
        foreach (q[i]) step(q[i].st, q[i].rdy, op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op;
        bus.mem_ready = 1'b0;
        bus.opcode    = OP_R;
        #3;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_outs", 32'(got_outs()), 32'(exp_out(0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the plan.
        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_R, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 3, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_ADDI, 0, 0);

        // Async reset while stalled in MRD.
        step(0, 1, OP_LW);
        step(1, 0, OP_LW);
        step(2, 0, OP_LW);
        step(3, 0, OP_LW);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mrd_state", 32'(bus.state), 32'd0);
        chk("rst_mrd_outs", 32'(got_outs()), 32'(exp_out(0, 0, 0)));
        @(posedge clk);
        #1 chk("rst_hold_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(OP_LW, 0, 1);

        // Random instruction mix with random stalls.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (op == OP_R || op == OP_LW || op == OP_SW ||
                           op == OP_BEQ || op == OP_J || op == OP_ADDI)
                        op = 6'($urandom);
                end
            endcase
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        // Trace must close back at fetch.
        step(0, 0, OP_R);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
